// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types, segment table and digit search for the scan controller
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // First set bit strictly after cur, wrapping within n digits; cur itself is found last.
    function automatic logic [2:0] next_enabled(input logic [7:0] mask,
                                                input logic [2:0] cur,
                                                input int         n);
        logic [2:0] res;
        logic       found;
        logic [3:0] idx;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = {1'b0, cur} + 4'(k);
            if (idx >= 4'(n)) begin
                idx = idx - 4'(n);
            end
            if (!found && (k <= n) && mask[idx[2:0]]) begin
                res   = idx[2:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational hex nibble to active-low seven-segment pattern
module seg_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - round-robin seven-segment digit scanner with frame-atomic updates
module seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    upd_valid,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    output logic                    upd_ready,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    output logic [NUM_DIGITS-1:0]   dig_on,
    output logic [6:0]              seg,
    output logic [2:0]              cur_digit,
    output logic                    frame_done
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              cur_q, cur_d;
    logic [NUM_DIGITS-1:0]   dig_on_q, dig_on_d;
    logic [6:0]              seg_q, seg_d;
    logic                    frame_done_q, frame_done_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pbuf_q, pbuf_d;
    logic                    pending_q, pending_d;

    logic                    apply;
    logic                    enter_visit;
    logic [7:0]              mask8;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg;

    assign mask8 = 8'(digit_mask);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_d        = cur_q;
        dig_on_d     = dig_on_q;
        frame_done_d = 1'b0;
        active_d     = active_q;
        pbuf_d       = pbuf_q;
        pending_d    = pending_q;
        apply        = 1'b0;
        enter_visit  = 1'b0;

        case (state_q)
            IDLE: begin
                apply    = pending_q;
                dig_on_d = '0;
                if (digit_mask != '0) begin
                    cur_d       = next_enabled(mask8, 3'(NUM_DIGITS - 1), NUM_DIGITS);
                    enter_visit = 1'b1;
                end
            end
            BLANK: begin
                if (cnt_q == '0) begin
                    state_d  = DWELL;
                    cnt_d    = DWELL_LOAD;
                    dig_on_d = NUM_DIGITS'(8'b1 << cur_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DWELL: begin
                if (cnt_q == '0) begin
                    if (digit_mask == '0) begin
                        state_d  = IDLE;
                        dig_on_d = '0;
                    end else begin
                        cur_d       = next_enabled(mask8, cur_q, NUM_DIGITS);
                        enter_visit = 1'b1;
                        // Wrapping back to an equal or lower index closes the frame
                        if (cur_d <= cur_q) begin
                            frame_done_d = 1'b1;
                            apply        = pending_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                dig_on_d = '0;
            end
        endcase

        if (enter_visit) begin
            if (BLANK_CYCLES == 0) begin
                state_d  = DWELL;
                cnt_d    = DWELL_LOAD;
                dig_on_d = NUM_DIGITS'(8'b1 << cur_d);
            end else begin
                state_d  = BLANK;
                cnt_d    = BLANK_LOAD;
                dig_on_d = '0;
            end
        end

        if (apply) begin
            active_d  = pbuf_q;
            pending_d = 1'b0;
        end

        // An update accepted on a boundary cycle waits for the next boundary
        if (upd_valid && !pending_q) begin
            pbuf_d    = upd_data;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cur_d == 3'(i)) begin
                nibble = active_d[4*i +: 4];
            end
        end
    end

    seg_decoder u_seg_decoder (
        .hex_i (nibble),
        .seg_o (dec_seg)
    );

    assign seg_d = (state_d == IDLE) ? SEG_BLANK : dec_seg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cur_q        <= 3'd0;
            dig_on_q     <= '0;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
            active_q     <= '0;
            pbuf_q       <= '0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            dig_on_q     <= dig_on_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            active_q     <= active_d;
            pbuf_q       <= pbuf_d;
            pending_q    <= pending_d;
        end
    end

    assign upd_ready  = ~pending_q;
    assign dig_on     = dig_on_q;
    assign seg        = seg_q;
    assign cur_digit  = cur_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - self-checking bench for seg_scan_controller
module tb_seg_scan_controller;

    localparam int N  = 2;
    localparam int DW = 4;
    localparam int BL = 1;

    typedef struct {
        logic [1:0] dig_on;
        logic [6:0] seg;
        logic [2:0] cur;
        logic       fd;
    } exp_t;

    logic [6:0] SEGS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk;
    logic       rst_a_n, upd_valid_a, upd_ready_a, fd_a;
    logic [7:0] upd_data_a;
    logic [1:0] mask_a, dig_on_a;
    logic [6:0] seg_a;
    logic [2:0] cur_a;

    logic       rst_b_n, upd_ready_b, fd_b;
    logic [1:0] mask_b, dig_on_b;
    logic [6:0] seg_b;
    logic [2:0] cur_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seg_scan_controller #(.NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) u_dut_a (
        .clk(clk), .reset(rst_a_n), .upd_valid(upd_valid_a), .upd_data(upd_data_a),
        .upd_ready(upd_ready_a), .digit_mask(mask_a), .dig_on(dig_on_a), .seg(seg_a),
        .cur_digit(cur_a), .frame_done(fd_a)
    );

    seg_scan_controller #(.NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(rst_b_n), .upd_valid(1'b0), .upd_data(8'h00),
        .upd_ready(upd_ready_b), .digit_mask(mask_b), .dig_on(dig_on_b), .seg(seg_b),
        .cur_digit(cur_b), .frame_done(fd_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Scan model: each visit is planned as a list of per-cycle outputs
    exp_t       q[$];
    exp_t       ce;
    logic [7:0] m_act;
    logic [7:0] m_pbuf;
    logic       m_pend;
    int         m_cur;
    bit         in_visit;

    function automatic int next_on(input logic [1:0] m, input int c);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (c + k) % N;
            if (((m >> idx) & 2'b01) != 2'b00) return idx;
        end
        return c;
    endfunction

    task automatic set_idle();
        ce.dig_on = 2'b00;
        ce.seg    = 7'h7F;
        ce.cur    = 3'(m_cur);
        ce.fd     = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_act    = 8'h00;
        m_pbuf   = 8'h00;
        m_pend   = 1'b0;
        m_cur    = 0;
        in_visit = 1'b0;
        set_idle();
    endtask

    task automatic plan_visit(input int d, input bit fd);
        exp_t       e;
        logic [3:0] nib;
        nib = 4'(m_act >> (4 * d));
        q.delete();
        for (int i = 0; i < BL; i++) begin
            e.dig_on = 2'b00;
            e.seg    = SEGS[nib];
            e.cur    = 3'(d);
            e.fd     = fd && (i == 0);
            q.push_back(e);
        end
        for (int i = 0; i < DW; i++) begin
            e.dig_on = 2'(1 << d);
            e.seg    = SEGS[nib];
            e.cur    = 3'(d);
            e.fd     = fd && (i == 0) && (BL == 0);
            q.push_back(e);
        end
        ce       = q.pop_front();
        m_cur    = d;
        in_visit = 1'b1;
    endtask

    task automatic model_step();
        bit xfer, apply, start, fd;
        int nxt;
        xfer  = upd_valid_a && !m_pend;
        apply = 1'b0;
        start = 1'b0;
        fd    = 1'b0;
        nxt   = 0;
        if (q.size() > 0) begin
            ce = q.pop_front();
        end else begin
            if (in_visit) begin
                if (mask_a != 2'b00) begin
                    nxt   = next_on(mask_a, m_cur);
                    fd    = (nxt <= m_cur);
                    apply = fd && m_pend;
                    start = 1'b1;
                end
            end else begin
                apply = m_pend;
                if (mask_a != 2'b00) begin
                    nxt   = next_on(mask_a, N - 1);
                    start = 1'b1;
                end
            end
            if (apply) begin
                m_act  = m_pbuf;
                m_pend = 1'b0;
            end
            if (start) begin
                plan_visit(nxt, fd);
            end else begin
                in_visit = 1'b0;
                set_idle();
            end
        end
        if (xfer) begin
            m_pbuf = upd_data_a;
            m_pend = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_a_n) model_reset();
            chk("dig_on", 32'(dig_on_a), 32'(ce.dig_on));
            chk("seg", 32'(seg_a), 32'(ce.seg));
            chk("cur_digit", 32'(cur_a), 32'(ce.cur));
            chk("frame_done", 32'(fd_a), 32'(ce.fd));
            chk("upd_ready", 32'(upd_ready_a), 32'(!m_pend));
            chk("dig_on_onehot", 32'($countones(dig_on_a) <= 1), 32'd1);
            if (rst_a_n) model_step();
        end
    end

    task automatic wait_fd(input string nm, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd_a && n < 40);
        chk(nm, 32'(fd_a), 32'd1);
        at = cyc;
    endtask

    task automatic step_in();
        @(posedge clk);
        #2;
    endtask

    int t1, t2;

    initial begin
        rst_a_n     = 1'b0;
        rst_b_n     = 1'b0;
        upd_valid_a = 1'b0;
        upd_data_a  = 8'h00;
        mask_a      = 2'b00;
        mask_b      = 2'b11;
        repeat (3) step_in();
        chk("rst_dig_on", 32'(dig_on_a), 32'h0);
        chk("rst_seg", 32'(seg_a), 32'h7F);
        chk("rst_cur", 32'(cur_a), 32'h0);
        chk("rst_fd", 32'(fd_a), 32'h0);
        chk("rst_ready", 32'(upd_ready_a), 32'h1);

        // Scan start and steady frame period
        mask_a  = 2'b11;
        rst_a_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t1_blank_dig_on", 32'(dig_on_a), 32'h0);
        chk("t1_blank_seg", 32'(seg_a), 32'h40);
        @(negedge clk);
        chk("t1_dwell_dig_on", 32'(dig_on_a), 32'h1);
        wait_fd("t1_fd_a", t1);
        chk("t1_fd_cur", 32'(cur_a), 32'h0);
        wait_fd("t1_fd_b", t2);
        chk("t1_period", 32'(t2 - t1), 32'd10);

        // Update mid-frame appears only at the wrap
        repeat (3) step_in();
        upd_valid_a = 1'b1;
        upd_data_a  = 8'h3A;
        step_in();
        upd_valid_a = 1'b0;
        @(negedge clk);
        chk("t2_ready_low", 32'(upd_ready_a), 32'h0);
        chk("t2_old_seg", 32'(seg_a), 32'h40);
        wait_fd("t2_fd", t1);
        chk("t2_d0_seg", 32'(seg_a), 32'h08);
        chk("t2_ready_back", 32'(upd_ready_a), 32'h1);
        repeat (5) @(negedge clk);
        chk("t2_d1_cur", 32'(cur_a), 32'h1);
        chk("t2_d1_seg", 32'(seg_a), 32'h30);

        // Transfer on the boundary cycle waits one more frame
        repeat (4) @(posedge clk);
        #2;
        upd_valid_a = 1'b1;
        upd_data_a  = 8'h55;
        wait_fd("t3_fd_a", t1);
        chk("t3_not_yet", 32'(seg_a), 32'h08);
        step_in();
        upd_valid_a = 1'b0;
        wait_fd("t3_fd_b", t1);
        chk("t3_applied", 32'(seg_a), 32'h12);

        // Only digit 1 enabled
        step_in();
        mask_a = 2'b10;
        wait_fd("t4_fd_a", t1);
        wait_fd("t4_fd_b", t1);
        wait_fd("t4_fd_c", t2);
        chk("t4_period", 32'(t2 - t1), 32'd5);
        chk("t4_cur", 32'(cur_a), 32'h1);

        // Mask drop mid-dwell finishes the visit, then idles
        step_in();
        mask_a = 2'b00;
        repeat (4) @(negedge clk);
        chk("t5_dwell_kept", 32'(dig_on_a), 32'h2);
        @(negedge clk);
        chk("t5_idle_dig_on", 32'(dig_on_a), 32'h0);
        chk("t5_idle_seg", 32'(seg_a), 32'h7F);
        repeat (2) step_in();
        mask_a = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk("t5_blank_dig_on", 32'(dig_on_a), 32'h0);
        chk("t5_blank_seg", 32'(seg_a), 32'h12);
        @(negedge clk);
        chk("t5_dwell_dig_on", 32'(dig_on_a), 32'h1);

        // Asynchronous reset mid-dwell with an update pending
        step_in();
        upd_valid_a = 1'b1;
        upd_data_a  = 8'h77;
        step_in();
        upd_valid_a = 1'b0;
        chk("t6_pending", 32'(upd_ready_a), 32'h0);
        rst_a_n = 1'b0;
        #1;
        chk("t6_async_dig_on", 32'(dig_on_a), 32'h0);
        chk("t6_async_seg", 32'(seg_a), 32'h7F);
        chk("t6_async_ready", 32'(upd_ready_a), 32'h1);

        // No blanking: digits hand over with no gap
        step_in();
        rst_b_n = 1'b1;
        @(negedge clk);
        chk("b_idle_dig_on", 32'(dig_on_b), 32'h0);
        chk("b_idle_ready", 32'(upd_ready_b), 32'h1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("b_dig_on", 32'(dig_on_b), ((i / 4) % 2 == 0) ? 32'h1 : 32'h2);
            chk("b_cur", 32'(cur_b), 32'((i / 4) % 2));
            chk("b_fd", 32'(fd_b), (i == 8) ? 32'h1 : 32'h0);
            chk("b_seg", 32'(seg_b), 32'h40);
        end
        step_in();
        rst_b_n = 1'b0;
        #1;
        chk("b_async_dig_on", 32'(dig_on_b), 32'h0);
        chk("b_async_seg", 32'(seg_b), 32'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
